// File: rtl/countdown_timer_core.sv
// Countdown engine: loads edited BCD digits, counts down once per prescaler wrap,
// and raises done/alarm_blink for DONE_SECS seconds when the value reaches zero.
module countdown_timer_core #(
  parameter int TICK_DIV  = 100000000,
  parameter int DONE_SECS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_mode,
  input  logic       start,
  input  logic       clear,
  input  logic [3:0] n_sec0,
  input  logic [3:0] n_sec1,
  input  logic [3:0] n_min0,
  input  logic [3:0] n_min1,
  input  logic [3:0] n_hrs0,
  input  logic [3:0] n_hrs1,
  output logic [3:0] t_sec0,
  output logic [3:0] t_sec1,
  output logic [3:0] t_min0,
  output logic [3:0] t_min1,
  output logic [3:0] t_hrs0,
  output logic [3:0] t_hrs1,
  output logic       running,
  output logic       paused,
  output logic       done,
  output logic       alarm_blink
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (DONE_SECS > 1) ? $clog2(DONE_SECS + 1) : 1;
  localparam logic [PW-1:0] PS_LAST   = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PS_HALF   = PW'(TICK_DIV / 2);
  localparam logic [AW-1:0] ACNT_LAST = AW'(DONE_SECS - 1);
  // Per-digit ceiling, index 0 = sec0 .. 5 = hrs1; also the borrow wrap value.
  localparam logic [5:0][3:0] DIG_MAX = {4'd2, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9};

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state_q, state_d;
  logic [5:0][3:0]  t_q, t_d, n_vec, n_clamped, t_dec;
  logic [PW-1:0]    ps_q, ps_d;
  logic [AW-1:0]    acnt_q, acnt_d;
  logic             borrow, t_zero, dec_zero, tick;

  assign n_vec = {n_hrs1, n_hrs0, n_min1, n_min0, n_sec1, n_sec0};

  always_comb begin
    n_clamped = n_vec;
    for (int i = 0; i < 6; i++)
      if (n_vec[i] > DIG_MAX[i]) n_clamped[i] = DIG_MAX[i];
  end

  // hrs1 never wraps: a borrow only reaches it when the total is nonzero.
  always_comb begin
    t_dec  = t_q;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (borrow) begin
        if (t_q[i] == 4'd0 && i < 5) begin
          t_dec[i] = DIG_MAX[i];
        end else begin
          t_dec[i] = t_q[i] - 4'd1;
          borrow   = 1'b0;
        end
      end
    end
  end

  assign t_zero   = (t_q == '0);
  assign dec_zero = (t_dec == '0);
  assign tick     = (ps_q == PS_LAST);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    ps_d    = ps_q;
    acnt_d  = acnt_q;
    if (clear) begin
      state_d = IDLE;
      t_d     = '0;
      ps_d    = '0;
      acnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (!t_zero) begin
              state_d = RUN;
              ps_d    = '0;
            end
          end else if (set_mode) begin
            t_d = n_clamped;
          end
        end
        RUN: begin
          if (start) begin
            state_d = PAUSE;
          end else if (tick) begin
            ps_d = '0;
            if (dec_zero) begin
              state_d = DONE;
              t_d     = '0;
              acnt_d  = '0;
            end else begin
              t_d = t_dec;
            end
          end else begin
            ps_d = ps_q + 1'b1;
          end
        end
        PAUSE: begin
          if (start)         state_d = t_zero ? IDLE : RUN;
          else if (set_mode) t_d     = n_clamped;
        end
        DONE: begin
          if (start) begin
            state_d = IDLE;
            ps_d    = '0;
            acnt_d  = '0;
          end else if (tick) begin
            ps_d = '0;
            if (acnt_q == ACNT_LAST) begin
              state_d = IDLE;
              acnt_d  = '0;
            end else begin
              acnt_d = acnt_q + 1'b1;
            end
          end else begin
            ps_d = ps_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      ps_q    <= '0;
      acnt_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      ps_q    <= ps_d;
      acnt_q  <= acnt_d;
    end
  end

  assign {t_hrs1, t_hrs0, t_min1, t_min0, t_sec1, t_sec0} = t_q;
  assign running     = (state_q == RUN);
  assign paused      = (state_q == PAUSE);
  assign done        = (state_q == DONE);
  assign alarm_blink = done && (ps_q < PS_HALF);

endmodule

// File: tb/tb_countdown_timer_core.sv
// Bench for countdown_timer_core: directed scenarios plus random stimulus
// checked every cycle against a seconds-based reference model.
module tb_countdown_timer_core;
  localparam int TD = 4;
  localparam int DS = 10;

  logic gclk = 1'b0;
  logic rst, set_mode, start, clear;
  logic [5:0][3:0] nd;
  logic [3:0] t_sec0, t_sec1, t_min0, t_min1, t_hrs0, t_hrs1;
  logic running, paused, done, alarm_blink;
  logic [23:0] t_all;

  always #5 gclk = ~gclk;

  countdown_timer_core #(.TICK_DIV(TD), .DONE_SECS(DS)) dut (
    .clk(gclk), .rst(rst), .set_mode(set_mode), .start(start), .clear(clear),
    .n_sec0(nd[0]), .n_sec1(nd[1]), .n_min0(nd[2]), .n_min1(nd[3]),
    .n_hrs0(nd[4]), .n_hrs1(nd[5]),
    .t_sec0(t_sec0), .t_sec1(t_sec1), .t_min0(t_min0), .t_min1(t_min1),
    .t_hrs0(t_hrs0), .t_hrs1(t_hrs1),
    .running(running), .paused(paused), .done(done), .alarm_blink(alarm_blink)
  );

  assign t_all = {t_hrs1, t_hrs0, t_min1, t_min0, t_sec1, t_sec0};

  int n_vec = 0, n_err = 0;
  // model: 0 idle, 1 run, 2 pause, 3 done; remaining time kept as plain seconds
  int m_mode = 0, m_secs = 0, m_ph = 0, m_acnt = 0;
  bit pre_ok = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600; m = (s / 60) % 60; x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic int load_secs();
    int mx[6] = '{9, 5, 9, 5, 9, 2};
    int d[6];
    for (int i = 0; i < 6; i++) d[i] = (int'(nd[i]) > mx[i]) ? mx[i] : int'(nd[i]);
    return (d[5] * 10 + d[4]) * 3600 + (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
  endfunction

  task automatic model_step(input logic r, input logic c, input logic s, input logic m);
    if (r || c) begin
      m_mode = 0; m_secs = 0; m_ph = 0; m_acnt = 0;
    end else begin
      case (m_mode)
        0: if (s) begin
             if (m_secs != 0) begin m_mode = 1; m_ph = 0; end
           end else if (m) m_secs = load_secs();
        1: if (s) m_mode = 2;
           else if (m_ph == TD - 1) begin
             m_ph = 0; m_secs--;
             if (m_secs == 0) begin m_mode = 3; m_acnt = 0; end
           end else m_ph++;
        2: if (s) m_mode = (m_secs != 0) ? 1 : 0;
           else if (m) m_secs = load_secs();
        default: if (s) begin m_mode = 0; m_ph = 0; m_acnt = 0; end
           else if (m_ph == TD - 1) begin
             m_ph = 0; m_acnt++;
             if (m_acnt == DS) begin m_mode = 0; m_acnt = 0; end
           end else m_ph++;
      endcase
    end
  endtask

  task automatic check_outs(input string pre);
    chk({pre, "t"}, 32'(t_all), 32'(to_bcd(m_secs)));
    chk({pre, "running"}, 32'(running), 32'(m_mode == 1));
    chk({pre, "paused"}, 32'(paused), 32'(m_mode == 2));
    chk({pre, "done"}, 32'(done), 32'(m_mode == 3));
    chk({pre, "alarm_blink"}, 32'(alarm_blink), 32'(m_mode == 3 && m_ph < TD / 2));
  endtask

  task automatic cyc(input logic r, input logic c, input logic s, input logic m);
    rst = r; clear = c; start = s; set_mode = m;
    if (pre_ok && (r || c || s)) begin
      #1 check_outs("pre_edge_");
    end
    model_step(r, c, s, m);
    @(posedge gclk);
    #1 check_outs("");
    rst = 0; clear = 0; start = 0; set_mode = 0;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic load(input logic [23:0] v);
    nd = v;
    cyc(0, 0, 0, 1);
  endtask

  initial begin
    rst = 1; clear = 0; start = 0; set_mode = 0; nd = '0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    pre_ok = 1;

    // load, start, observe the ticks
    load(24'h000105); cyc(0, 0, 1, 0);
    idle_n(4);  chk("tp1_first", 32'(t_all), 32'h000104);
    idle_n(16); chk("tp1_20cyc", 32'(t_all), 32'h000100);
    idle_n(4);  chk("tp1_borrow", 32'(t_all), 32'h000059);

    // full borrow chains
    cyc(0, 1, 0, 0); load(24'h010000); cyc(0, 0, 1, 0);
    idle_n(4); chk("tp2_1h", 32'(t_all), 32'h005959);
    cyc(0, 1, 0, 0); load(24'h100000); cyc(0, 0, 1, 0);
    idle_n(4); chk("tp2_10h", 32'(t_all), 32'h095959);

    // expiry, alarm duration, start-abort of DONE
    cyc(0, 1, 0, 0); load(24'h000002); cyc(0, 0, 1, 0);
    idle_n(4); chk("tp3_one", 32'(t_all), 32'h000001);
    idle_n(4); chk("tp3_done", 32'(done), 32'd1); chk("tp3_run", 32'(running), 32'd0);
    idle_n(DS * TD - 1); chk("tp3_still_done", 32'(done), 32'd1);
    idle_n(1); chk("tp3_expired", 32'(done), 32'd0);
    load(24'h000001); cyc(0, 0, 1, 0); idle_n(4);
    chk("tp3_done2", 32'(done), 32'd1);
    cyc(0, 0, 1, 0); chk("tp3_abort", 32'(done), 32'd0);

    // pause at prescaler 2, hold, resume
    load(24'h000030); cyc(0, 0, 1, 0); idle_n(2);
    cyc(0, 0, 1, 0); idle_n(20);
    chk("tp4_hold_t", 32'(t_all), 32'h000030); chk("tp4_paused", 32'(paused), 32'd1);
    cyc(0, 0, 1, 0); idle_n(1); chk("tp4_no_tick", 32'(t_all), 32'h000030);
    idle_n(1); chk("tp4_tick", 32'(t_all), 32'h000029);

    // zero start, clear and reset mid-run
    cyc(0, 1, 0, 0); cyc(0, 0, 1, 0); chk("tp5_zero_start", 32'(running), 32'd0);
    load(24'h000005); cyc(0, 0, 1, 0); idle_n(2);
    cyc(0, 1, 0, 0); chk("tp5_clear", 32'(t_all), 32'h0);
    load(24'h000005); cyc(0, 0, 1, 0); idle_n(2);
    cyc(1, 0, 0, 0); chk("tp5_rst", 32'(running), 32'd0);

    // clamp on load, set_mode ignored while running
    nd = '0; nd[1] = 4'd7; nd[5] = 4'd3; nd[2] = 4'd12; cyc(0, 0, 0, 1);
    chk("tp6_clamp", 32'(t_all), 32'h200950);
    cyc(0, 0, 1, 0); nd = 24'h010101; cyc(0, 0, 0, 1);
    chk("tp6_run_load", 32'(t_all), 32'h200950);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom % 2) begin
        for (int i = 0; i < 6; i++) nd[i] = 4'($urandom % 16);
      end else begin
        nd = '0; nd[0] = 4'($urandom % 16);
      end
      cyc(($urandom % 300) == 0, ($urandom % 80) == 0,
          ($urandom % 20) == 0, ($urandom % 6) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/countdown_timer_core.md
Name: countdown_timer_core

Overview:
Countdown engine directly downstream of the timer cursor/edit block. It consumes the edited digits n_sec0..n_hrs1 and holds the live countdown value t_sec0..t_hrs1. That live value is fed back to the editor as its current-value input and also drives the display path. The block loads, runs, pauses and expires the timer, and produces the done/alarm indications for the buzzer and LED stage.

Parameters:
TICK_DIV, 100000000, clk cycles per 1 s countdown tick (benches use 4)
DONE_SECS, 10, duration of the alarm in DONE state, in seconds

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
set_mode  input  1  level; editor active (timer mode and edit button held); loads n_* into t_*
start  input  1  single-cycle pulse; start/pause toggle
clear  input  1  single-cycle pulse; abort and zero the timer
n_sec0, n_sec1, n_min0, n_min1, n_hrs0, n_hrs1  input  4 each  edited BCD digits
t_sec0, t_sec1, t_min0, t_min1, t_hrs0, t_hrs1  output  4 each  live countdown BCD digits (registered)
running  output  1  high in RUN
paused  output  1  high in PAUSE
done  output  1  high in DONE
alarm_blink  output  1  done gated by a 1 Hz square wave

Behaviour:
- All state changes occur on posedge clk. Reset is synchronous.
- rst=1: state=IDLE, all t_*=0, prescaler=0, alarm counter=0. running, paused, done and alarm_blink are all 0.
- Per-cycle priority: rst > clear > start > set_mode > tick.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE:
    - set_mode=1: every cycle, t_* <= clamp(n_*).
    - start with t_* nonzero: go to RUN, prescaler <= 0.
    - start with t_* = 00:00:00: ignored, stay in IDLE.
  - RUN:
    - Prescaler counts 0..TICK_DIV-1. The tick fires in the cycle where the prescaler equals TICK_DIV-1, and the prescaler then wraps to 0.
    - On a tick, t_* are decremented by one second (BCD arithmetic).
    - If the decremented value is 00:00:00: t_* <= 0, go to DONE, alarm counter <= 0, prescaler <= 0.
    - start: go to PAUSE. The prescaler value is held and no tick is taken in that cycle.
    - set_mode is ignored.
  - PAUSE:
    - The prescaler is frozen.
    - set_mode=1 loads clamp(n_*) into t_* as in IDLE.
    - start with t_* nonzero: go to RUN with the prescaler resuming from its held value.
    - start with t_* = 00:00:00: go to IDLE.
  - DONE:
    - The prescaler free-runs. Each wrap increments the alarm counter.
    - When the alarm counter reaches DONE_SECS: go to IDLE.
    - start or clear: go to IDLE immediately.
    - set_mode is ignored.
    - t_* stay 0.
  - clear in any state: go to IDLE, all t_* <= 0, prescaler <= 0.
- BCD decrement with borrow chain:
  - sec0: 0 -> 9 with borrow; sec1: 0 -> 5 with borrow.
  - min0: 0 -> 9 with borrow; min1: 0 -> 5 with borrow.
  - hrs0: 0 -> 9 with borrow; hrs1 decrements with no wrap (it is never at 0 while a borrow arrives, because a zero total has already gone to DONE).
- Clamp on load:
  - sec0, min0, hrs0: values greater than 9 are loaded as 9.
  - sec1, min1: values greater than 5 are loaded as 5.
  - hrs1: values greater than 2 are loaded as 2.
  - Maximum loadable value is 29:59:59; this range is accepted.
- Outputs:
  - running, paused and done are decoded directly from the state register, with no extra delay.
  - alarm_blink = done AND (prescaler < TICK_DIV/2).
- Latency:
  - A start pulse in cycle N gives running=1 in cycle N+1.
  - The first decrement is visible TICK_DIV cycles after running rises.
- A set_mode and start in the same cycle: start wins and no load happens that cycle.

Test Plan:
1. TICK_DIV=4. Load 00:01:05 via set_mode for 1 cycle, then pulse start -> t=00:01:04 after 4 cycles; 00:01:00 after 20 cycles; 00:00:59 on the next tick.
2. Load 01:00:00 and run -> the first tick gives 00:59:59 (full borrow chain); 10:00:00 -> 09:59:59.
3. Load 00:00:02 and run -> 00:00:01, then 00:00:00 with done=1 and running=0. alarm_blink toggles every 2 cycles. Return to IDLE after DONE_SECS*4 cycles; also a start pulse in DONE returns to IDLE the next cycle.
4. Pause at prescaler=2 and hold 20 cycles -> digits and prescaler unchanged, paused=1. Pulse start -> the next decrement occurs 2 cycles later.
5. start in IDLE with all zeros -> stays IDLE. clear mid-RUN -> zeros and IDLE next cycle. rst asserted mid-RUN -> same result, and only at a clock edge.
6. set_mode with n_sec1=7, n_hrs1=3, n_min0=12 -> t_sec1=5, t_hrs1=2, t_min0=9. set_mode during RUN -> t_* unaffected.
